register_scoreboard_decoder: RTL

Parametrised successor to the register-file write decoder. Decodes the writeback destination into a registered one-hot write-enable for the register file, and keeps a busy bitmap (scoreboard) of registers with an issued but not yet written-back result. Drives a combinational stall to the issue stage on RAW/WAW hazards. Sits between the issue stage, the writeback stage and the register file.

---
 rtl/register_scoreboard_decoder.sv | 98 +++++++++
 1 files changed

// File: rtl/register_scoreboard_decoder.sv
// Register scoreboard and writeback decoder.
// Decodes the writeback destination into a registered one-hot register-file
// write strobe, tracks registers whose results are still in flight, and
// raises a combinational stall toward issue on RAW/WAW hazards. A writeback
// landing in the same cycle as a dependent issue resolves the hazard.
module register_scoreboard_decoder #(
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_REGS     = 2**ADDR_WIDTH,
    parameter int R0_HARDWIRED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic [ADDR_WIDTH-1:0] src_a_addr,
    input  logic [ADDR_WIDTH-1:0] src_b_addr,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [NUM_REGS-1:0]   write_enable,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  wb_orphan
);

    // Register 0 is a constant when hardwired: it never becomes busy and is
    // never strobed for writing.
    localparam logic R0_FIXED = (R0_HARDWIRED != 0);

    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;
    logic [NUM_REGS-1:0]   write_enable_reg;
    logic [NUM_REGS-1:0]   wb_clear;
    logic [NUM_REGS-1:0]   issue_set;
    logic [NUM_REGS-1:0]   eff_busy;
    logic [ADDR_WIDTH:0]   pending_count_reg;
    logic [ADDR_WIDTH:0]   pending_count_next;
    logic                  wb_orphan_reg;
    logic                  wb_orphan_next;
    logic                  issue_ok;
    logic                  wb_to_r0;

    // Per-register decode of the writeback clear and the issue set.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            localparam logic IS_FIXED = R0_FIXED && (gi == 0);
            assign wb_clear[gi]  = wb_en && (wb_addr == ADDR_WIDTH'(gi)) && !IS_FIXED;
            assign issue_set[gi] = issue_ok && (issue_addr == ADDR_WIDTH'(gi)) && !IS_FIXED;
        end
    endgenerate

    // A writeback in this cycle already satisfies the pending result, so it
    // is removed from the hazard view before the stall check.
    assign eff_busy = busy_reg & ~wb_clear;

    // Sources give the RAW check, the destination gives the WAW check.
    assign stall    = issue_en & (eff_busy[src_a_addr] |
                                  eff_busy[src_b_addr] |
                                  eff_busy[issue_addr]);
    assign issue_ok = issue_en & ~stall;

    // Set is applied after clear so a re-issue to the register being written
    // back keeps it busy.
    assign busy_next = eff_busy | issue_set;

    assign wb_to_r0       = R0_FIXED && (wb_addr == '0);
    assign wb_orphan_next = wb_en & ~busy_reg[wb_addr] & ~wb_to_r0;

    // Population count of the next scoreboard, one bit wider than the address
    // so a fully busy file is representable.
    always_comb begin
        pending_count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_count_next = pending_count_next + (ADDR_WIDTH+1)'(busy_next[i]);
        end
    end

    // State update; reset discards pending work and suppresses any strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg          <= '0;
            write_enable_reg  <= '0;
            pending_count_reg <= '0;
            wb_orphan_reg     <= 1'b0;
        end else begin
            busy_reg          <= busy_next;
            write_enable_reg  <= wb_clear;
            pending_count_reg <= pending_count_next;
            wb_orphan_reg     <= wb_orphan_next;
        end
    end

    assign busy          = busy_reg;
    assign write_enable  = write_enable_reg;
    assign pending_count = pending_count_reg;
    assign wb_orphan     = wb_orphan_reg;

endmodule
